unary_multi_adder: RTL and testbench
====================================

// Module: unary_multi_adder
// PURPOSE
// - Signed N-input unary (pulse-count) adder for the unary shift-MAC datapath; successor to the 2-input unary adder.
// - Each cycle samples N_IN pulse lines; each line is individually marked positive or negative.
// - Buffers the net count and re-emits it serially at up to 1 pulse/cycle on out (positive) or out_neg (negative).
// - Sits between the unary multiplier lanes and the downstream pulse-counting accumulator.
// PARAMETERS
// - N_IN   4  number of unary input channels (>=2)
// - CNT_W  8  signed pending-count width; elaboration error if CNT_W < $clog2(N_IN+1)+2
// PORTS
// - clk      in   1      clock; all state updates on posedge
// - reset_n  in   1      asynchronous active-low reset
// - clear    in   1      synchronous flush of pending count and overflow flag
// - in       in   N_IN   one unary pulse per channel per cycle
// - neg      in   N_IN   per-channel sign, sampled with in: 1 = pulse subtracts
// - out      out  1      positive output pulse stream
// - out_neg  out  1      negative output pulse stream
// - busy     out  1      pending count != 0
// - pending  out  CNT_W  signed buffered net count, for observability
// - overflow out  1      sticky: saturation occurred since last clear/reset
// BEHAVIOUR
// - State: signed register P (CNT_W bits) and register ovf. Outputs decode registered state only; no in->out combinational path.
//   out = (P > 0); out_neg = (P < 0); busy = (P != 0); pending = P; overflow = ovf.
// - Reset (async, reset_n=0): P=0, ovf=0, so out=out_neg=busy=overflow=0 and pending=0, immediately and held until reset_n=1.
// - Reset mid-operation discards all buffered pulses; no pulse is emitted after release until new input.
// - Per cycle: d = popcount(in & ~neg) - popcount(in & neg), range -N_IN..+N_IN.
//   Sum S = P + d - out + out_neg, computed in CNT_W+1 signed bits.
// - Saturation: PMAX = 2^(CNT_W-1)-1; P_next = clamp(S, -PMAX, +PMAX).
//   ovf set if S is out of range; excess pulses are dropped. -2^(CNT_W-1) never occurs.
// - Latency: pulses sampled at edge t first show on out/out_neg in the cycle after edge t. Emission rate max 1/cycle.
// - Opposite-sign pulses in the same cycle cancel in d.
// - Emission and arrival in the same cycle are combined in one update; out and out_neg are never both high.
// - Sign change: when S crosses zero, P takes the new sign directly.
//   out/out_neg switch on the next cycle with no idle cycle required.
// - clear=1 at edge t: P_next=0 and ovf_next=0; in/neg that cycle are discarded.
//   The pulse visible during that cycle (decoded from old P) still counts as emitted.
//   clear has priority over saturation and ovf set.
// - Invariant (no saturation): sum(out) - sum(out_neg) == sum of signed input pulses since last clear, once busy=0.
// STRUCTURE
// - unary_pkg: CNT_W-independent helpers; typedef of the sign encoding; function clamp_signed.
// - Sub-module unary_popcount #(N): combinational popcount, instantiated twice (positive and negative masks).
// - Top: one always_ff (async reset) for P/ovf plus combinational sum/clamp. Target ~150-250 lines total.
// TESTING
// - The bench counts out and out_neg pulses with counters cleared alongside the DUT clear (N_IN=4, CNT_W=8 unless stated).
// 1. Reset: reset_n low mid-burst (P=9) -> out, out_neg, busy, overflow = 0 and pending = 0 within the same cycle.
//    Then 20 idle cycles -> 0 pulses.
// 2. in=4'b1111, neg=0 for 3 cycles, then 0 -> exactly 12 contiguous out pulses, the first one cycle after the first sample.
//    busy falls after the 12th pulse; out_neg never asserted.
// 3. ch0 positive and ch1 negative, 7 simultaneous pulses -> 0 pulses on both outputs; pending stays 0.
// 4. ch0 positive 5 cycles, then ch2 negative 8 cycles -> count(out) - count(out_neg) == -3.
//    out and out_neg are never both high; pending=0 after drain.
// 5. CNT_W=6: in=4'b1111, neg=0 for 12 cycles -> pending peaks at 31 and never exceeds it.
//    overflow=1 from the 11th update; total out pulses = 42.
// 6. Pending=20, clear for 1 cycle -> next cycle pending=0, out=0, overflow=0.
//    Inputs asserted during the clear cycle produce no pulses.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared definitions for the unary pulse-count datapath. Nothing here depends on
// the pending-count width.
package unary_pkg;

    // Sign encoding of a per-channel neg line.
    typedef enum logic {
        SIGN_POS = 1'b0,
        SIGN_NEG = 1'b1
    } sign_e;

    // Symmetric clamp to [-limit, +limit].
    function automatic int clamp_signed(input int value, input int limit);
        if (value > limit)  return limit;
        if (value < -limit) return -limit;
        return value;
    endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational population count of an N-bit pulse vector.
module unary_popcount #(
    parameter int N = 4
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   count
);
    localparam int CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + {{(CW-1){1'b0}}, bits[i]};
        end
    end

endmodule

// File: rtl/unary_multi_adder.sv
// Signed N-input unary adder: nets the pulses arriving on N_IN lines into a saturating
// pending count and re-emits that count serially on out / out_neg.
module unary_multi_adder
    import unary_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [N_IN-1:0]         in,
    input  logic [N_IN-1:0]         neg,
    output logic                    out,
    output logic                    out_neg,
    output logic                    busy,
    output logic signed [CNT_W-1:0] pending,
    output logic                    overflow
);
    localparam int PC_W = $clog2(N_IN + 1);
    localparam int PMAX = 2 ** (CNT_W - 1) - 1;

    if (N_IN < 2) begin : g_bad_n_in
        $error("unary_multi_adder: N_IN must be at least 2");
    end
    if (CNT_W < PC_W + 2) begin : g_bad_cnt_w
        $error("unary_multi_adder: CNT_W too small for N_IN");
    end

    logic signed [CNT_W-1:0] p_q;
    logic                    ovf_q;

    logic [N_IN-1:0] pos_mask;
    logic [N_IN-1:0] neg_mask;
    logic [PC_W-1:0] pos_cnt;
    logic [PC_W-1:0] neg_cnt;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            pos_mask[i] = in[i] && (sign_e'(neg[i]) == SIGN_POS);
            neg_mask[i] = in[i] && (sign_e'(neg[i]) == SIGN_NEG);
        end
    end

    unary_popcount #(.N(N_IN)) u_pop_pos (.bits(pos_mask), .count(pos_cnt));
    unary_popcount #(.N(N_IN)) u_pop_neg (.bits(neg_mask), .count(neg_cnt));

    // The pulse currently on out/out_neg is retired in the same update that absorbs
    // new arrivals, so a sign change needs no idle cycle.
    logic signed [CNT_W:0]   sum;
    int                      sum_i;
    logic                    sat;
    logic signed [CNT_W-1:0] p_next;

    always_comb begin
        sum = $signed({p_q[CNT_W-1], p_q})
            + $signed((CNT_W+1)'(pos_cnt))
            - $signed((CNT_W+1)'(neg_cnt))
            - $signed((CNT_W+1)'(out))
            + $signed((CNT_W+1)'(out_neg));
        sum_i  = int'(sum);
        sat    = (sum_i > PMAX) || (sum_i < -PMAX);
        p_next = CNT_W'(clamp_signed(sum_i, PMAX));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            p_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            p_q <= p_next;
            if (sat) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign out      = !p_q[CNT_W-1] && (p_q != '0);
    assign out_neg  = p_q[CNT_W-1];
    assign busy     = (p_q != '0);
    assign pending  = p_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_unary_multi_adder.sv
// Bench for unary_multi_adder: an 8-bit and a 6-bit instance share stimulus and are
// compared against a pulse-budget model driven from the same inputs.
module tb_unary_multi_adder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] in_s = 4'b0;
    logic [3:0] neg_s = 4'b0;

    logic       out8, out_neg8, busy8, ovf8;
    logic [7:0] pend8;
    logic       out6, out_neg6, busy6, ovf6;
    logic [5:0] pend6;

    int tests = 0;
    int fails = 0;

    // Model state: outstanding net pulses and sticky overflow per instance.
    int m8 = 0;
    int m6 = 0;
    bit mo8 = 1'b0;
    bit mo6 = 1'b0;

    int cp8 = 0, cn8 = 0, cp6 = 0, cn6 = 0;

    always #5 clk = ~clk;

    unary_multi_adder #(.N_IN(4), .CNT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in(in_s), .neg(neg_s),
        .out(out8), .out_neg(out_neg8), .busy(busy8), .pending(pend8), .overflow(ovf8)
    );

    unary_multi_adder #(.N_IN(4), .CNT_W(6)) dut6 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in(in_s), .neg(neg_s),
        .out(out6), .out_neg(out_neg6), .busy(busy6), .pending(pend6), .overflow(ovf6)
    );

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    // Owed pulses grow by the signed arrivals, shrink by the one pulse on the wire,
    // and anything beyond +/-limit is lost.
    task automatic model_update(input int d, input bit clr);
        int s8, s6;
        s8 = m8 + d - sgn(m8);
        s6 = m6 + d - sgn(m6);
        if (clr) begin
            m8 = 0; mo8 = 1'b0; m6 = 0; mo6 = 1'b0;
        end else begin
            if (s8 > 127 || s8 < -127) mo8 = 1'b1;
            if (s6 > 31 || s6 < -31)   mo6 = 1'b1;
            m8 = (s8 > 127) ? 127 : ((s8 < -127) ? -127 : s8);
            m6 = (s6 > 31)  ? 31  : ((s6 < -31)  ? -31  : s6);
        end
    endtask

    task automatic cycle(input logic [3:0] i, input logic [3:0] n, input logic clr);
        in_s = i; neg_s = n; clear = clr;
        @(posedge clk);
        model_update($countones(i & ~n) - $countones(i & n), clr);
        #1;
        if (out8)     cp8++;
        if (out_neg8) cn8++;
        if (out6)     cp6++;
        if (out_neg6) cn6++;
    endtask

    task automatic zero_counts();
        cp8 = 0; cn8 = 0; cp6 = 0; cn6 = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if ({out8, out_neg8, busy8, ovf8} !== 4'b0) begin fails++;
            $display("FAIL reset_flags: got %b expected 0000", {out8, out_neg8, busy8, ovf8}); end
        tests++; if (pend8 !== 8'd0) begin fails++;
            $display("FAIL reset_pending: got %0d expected 0", pend8); end
        reset_n = 1'b1;
        repeat (3) cycle(4'b1111, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0000, 1'b0);
        tests++; if (int'($signed(pend8)) !== 9) begin fails++;
            $display("FAIL reset_preload: got %0d expected 9", $signed(pend8)); end
        #3 reset_n = 1'b0;
        #1;
        tests++; if (out8 !== 1'b0) begin fails++; $display("FAIL reset_mid_out: got %b expected 0", out8); end
        tests++; if (out_neg8 !== 1'b0) begin fails++; $display("FAIL reset_mid_out_neg: got %b expected 0", out_neg8); end
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_mid_busy: got %b expected 0", busy8); end
        tests++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL reset_mid_overflow: got %b expected 0", ovf8); end
        tests++; if (pend8 !== 8'd0) begin fails++; $display("FAIL reset_mid_pending: got %0d expected 0", pend8); end
        m8 = 0; m6 = 0; mo8 = 1'b0; mo6 = 1'b0;
        #2 reset_n = 1'b1;
        zero_counts();
        repeat (20) cycle(4'b0000, 4'b0000, 1'b0);
        tests++; if (cp8 !== 0) begin fails++; $display("FAIL reset_idle_out: got %0d expected 0", cp8); end
        tests++; if (cn8 !== 0) begin fails++; $display("FAIL reset_idle_out_neg: got %0d expected 0", cn8); end
    endtask

    task automatic test_burst();
        int first = -1;
        int bad = 0;
        int negseen = 0;
        logic b12 = 1'b0, b13 = 1'b1;
        zero_counts();
        for (int k = 1; k <= 25; k++) begin
            cycle((k <= 3) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0);
            if (out8 && first < 0) first = k;
            if (out8 !== (k <= 12)) bad++;
            if (out_neg8) negseen++;
            if (k == 12) b12 = busy8;
            if (k == 13) b13 = busy8;
        end
        tests++; if (cp8 !== 12) begin fails++; $display("FAIL burst_count: got %0d expected 12", cp8); end
        tests++; if (first !== 1) begin fails++; $display("FAIL burst_latency: got %0d expected 1", first); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL burst_contiguous: got %0d bad cycles expected 0", bad); end
        tests++; if (negseen !== 0) begin fails++; $display("FAIL burst_out_neg: got %0d expected 0", negseen); end
        tests++; if (b12 !== 1'b1) begin fails++; $display("FAIL burst_busy_last: got %b expected 1", b12); end
        tests++; if (b13 !== 1'b0) begin fails++; $display("FAIL burst_busy_fall: got %b expected 0", b13); end
    endtask

    task automatic test_cancel();
        int bad = 0;
        zero_counts();
        for (int k = 0; k < 12; k++) begin
            if (k < 7) cycle(4'b0011, 4'b0010, 1'b0);
            else       cycle(4'b0000, 4'b0000, 1'b0);
            if (pend8 !== 8'd0) bad++;
        end
        tests++; if (cp8 !== 0) begin fails++; $display("FAIL cancel_out: got %0d expected 0", cp8); end
        tests++; if (cn8 !== 0) begin fails++; $display("FAIL cancel_out_neg: got %0d expected 0", cn8); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL cancel_pending: got %0d nonzero cycles expected 0", bad); end
    endtask

    task automatic test_sign_change();
        int both = 0;
        int mism = 0;
        zero_counts();
        for (int k = 0; k < 33; k++) begin
            if (k < 5)       cycle(4'b0001, 4'b0000, 1'b0);
            else if (k < 13) cycle(4'b0100, 4'b0100, 1'b0);
            else             cycle(4'b0000, 4'b0000, 1'b0);
            if (out8 && out_neg8) both++;
            if (int'($signed(pend8)) !== m8) mism++;
        end
        tests++; if (cp8 - cn8 !== -3) begin fails++; $display("FAIL sign_net: got %0d expected -3", cp8 - cn8); end
        tests++; if (both !== 0) begin fails++; $display("FAIL sign_both_high: got %0d expected 0", both); end
        tests++; if (pend8 !== 8'd0) begin fails++; $display("FAIL sign_drain: got %0d expected 0", $signed(pend8)); end
        tests++; if (mism !== 0) begin fails++; $display("FAIL sign_model: got %0d mismatching cycles expected 0", mism); end
    endtask

    task automatic test_saturation();
        int max6 = -1000;
        int mism = 0;
        logic ov10 = 1'b1, ov11 = 1'b0;
        zero_counts();
        for (int k = 1; k <= 60; k++) begin
            cycle((k <= 12) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0);
            if (int'($signed(pend6)) > max6) max6 = int'($signed(pend6));
            if (k == 10) ov10 = ovf6;
            if (k == 11) ov11 = ovf6;
            if (int'($signed(pend6)) !== m6) mism++;
        end
        tests++; if (max6 !== 31) begin fails++; $display("FAIL sat_peak: got %0d expected 31", max6); end
        tests++; if (ov10 !== 1'b0) begin fails++; $display("FAIL sat_ovf_early: got %b expected 0", ov10); end
        tests++; if (ov11 !== 1'b1) begin fails++; $display("FAIL sat_ovf_11th: got %b expected 1", ov11); end
        tests++; if (cp6 !== 42) begin fails++; $display("FAIL sat_total: got %0d expected 42", cp6); end
        tests++; if (cn6 !== 0) begin fails++; $display("FAIL sat_out_neg: got %0d expected 0", cn6); end
        tests++; if (ovf6 !== 1'b1) begin fails++; $display("FAIL sat_sticky: got %b expected 1", ovf6); end
        tests++; if (mism !== 0) begin fails++; $display("FAIL sat_model: got %0d mismatching cycles expected 0", mism); end
        tests++; if (cp8 !== 48) begin fails++; $display("FAIL sat_wide_total: got %0d expected 48", cp8); end
        tests++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL sat_wide_ovf: got %b expected 0", ovf8); end
    endtask

    task automatic test_clear();
        repeat (6) cycle(4'b1111, 4'b0000, 1'b0);
        cycle(4'b0011, 4'b0000, 1'b0);
        tests++; if (int'($signed(pend8)) !== 20) begin fails++;
            $display("FAIL clear_preload: got %0d expected 20", $signed(pend8)); end
        zero_counts();
        cycle(4'b1111, 4'b0000, 1'b1);
        tests++; if (pend8 !== 8'd0) begin fails++; $display("FAIL clear_pending: got %0d expected 0", $signed(pend8)); end
        tests++; if (out8 !== 1'b0) begin fails++; $display("FAIL clear_out: got %b expected 0", out8); end
        tests++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL clear_ovf: got %b expected 0", ovf8); end
        tests++; if (ovf6 !== 1'b0) begin fails++; $display("FAIL clear_ovf_sticky: got %b expected 0", ovf6); end
        repeat (10) cycle(4'b0000, 4'b0000, 1'b0);
        tests++; if (cp8 + cn8 !== 0) begin fails++; $display("FAIL clear_no_pulses: got %0d expected 0", cp8 + cn8); end
    endtask

    task automatic test_random();
        logic [3:0] i, n;
        logic clr;
        cycle(4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < 400; k++) begin
            i = 4'($urandom_range(0, 15));
            if (k < 200) n = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            else         n = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 49) == 0);
            cycle(i, n, clr);
            tests++; if (int'($signed(pend8)) !== m8) begin fails++;
                $display("FAIL rand_pending8 @%0d: got %0d expected %0d", k, $signed(pend8), m8); end
            tests++; if (int'($signed(pend6)) !== m6) begin fails++;
                $display("FAIL rand_pending6 @%0d: got %0d expected %0d", k, $signed(pend6), m6); end
            tests++; if ({out8, out_neg8} !== {m8 > 0, m8 < 0}) begin fails++;
                $display("FAIL rand_outs8 @%0d: got %b expected %b", k, {out8, out_neg8}, {m8 > 0, m8 < 0}); end
            tests++; if ({out6, out_neg6, busy6} !== {m6 > 0, m6 < 0, m6 != 0}) begin fails++;
                $display("FAIL rand_outs6 @%0d: got %b expected %b", k, {out6, out_neg6, busy6}, {m6 > 0, m6 < 0, m6 != 0}); end
            tests++; if ({ovf8, ovf6} !== {mo8, mo6}) begin fails++;
                $display("FAIL rand_overflow @%0d: got %b expected %b", k, {ovf8, ovf6}, {mo8, mo6}); end
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_cancel();
        test_sign_change();
        test_saturation();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
